// File: rtl/sum_window_acc.sv
// rtl/sum_window_acc.sv - windowed accumulator of adder sums with zero count, max and valid/ready result
// Build option: define SUM_WINDOW_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module sum_window_acc #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W+1:0]     sm_r,
  input  logic             sm_zero_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [W+1:0]     max_out,
  output logic             ovf
);

  localparam int SC_W = $clog2(N);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SC_W-1:0]   sample_cnt;
  logic              last_sample;
  logic              accept;
  logic              consume;
  logic [ACC_W:0]    acc_sum;
  logic              carry;
  logic [ACC_W-1:0]  acc_nxt;

  assign last_sample = (sample_cnt == SC_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    consume   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last_sample) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        consume   = out_ready;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // One extra bit on the adder exposes the carry out of ACC_W bits.
  always_comb begin
    acc_sum = {1'b0, acc_out} + {{(ACC_W + 1 - (W + 2)){1'b0}}, sm_r};
    carry   = acc_sum[ACC_W];
    acc_nxt = acc_sum[ACC_W-1:0];
`ifdef SUM_WINDOW_ACC_SAT_EN
    if (ovf || carry) begin
      acc_nxt = {ACC_W{1'b1}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      acc_out    <= '0;
      zero_cnt   <= '0;
      max_out    <= '0;
      ovf        <= 1'b0;
    end else if (consume) begin
      acc_out  <= '0;
      zero_cnt <= '0;
      max_out  <= '0;
      ovf      <= 1'b0;
    end else if (accept) begin
      sample_cnt <= last_sample ? '0 : sample_cnt + SC_W'(1);
      acc_out    <= acc_nxt;
      ovf        <= ovf | carry;
      if (sm_zero_r) begin
        zero_cnt <= zero_cnt + CNT_W'(1);
      end
      if (sm_r > max_out) begin
        max_out <= sm_r;
      end
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// tb/tb_sum_window_acc.sv - directed self-checking bench for sum_window_acc (default and ACC_W=10 instances)
module tb_sum_window_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  sm_r;
  logic        sm_zero_r;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [11:0] acc_out;
  logic [2:0]  zero_cnt;
  logic [9:0]  max_out;
  logic        ovf;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [9:0]  acc_out_s;
  logic [2:0]  zero_cnt_s;
  logic [9:0]  max_out_s;
  logic        ovf_s;

  int checks = 0;
  int errors = 0;

  sum_window_acc #(.W(8), .N(4), .ACC_W(12), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sm_r(sm_r), .sm_zero_r(sm_zero_r), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .zero_cnt(zero_cnt), .max_out(max_out), .ovf(ovf)
  );

  sum_window_acc #(.W(8), .N(4), .ACC_W(10), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .sm_r(sm_r), .sm_zero_r(sm_zero_r), .out_valid(out_valid_s), .out_ready(out_ready),
    .acc_out(acc_out_s), .zero_cnt(zero_cnt_s), .max_out(max_out_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input logic z);
    in_valid  = 1'b1;
    sm_r      = 10'(v);
    sm_zero_r = z;
    step();
    in_valid  = 1'b0;
    sm_zero_r = 1'b0;
  endtask

  task automatic check_result(input string tag, input int acc, input int zc, input int mx, input int ov);
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_acc"}, 32'(acc_out), 32'(acc));
    check({tag, "_zero_cnt"}, 32'(zero_cnt), 32'(zc));
    check({tag, "_max"}, 32'(max_out), 32'(mx));
    check({tag, "_ovf"}, 32'(ovf), 32'(ov));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_acc"}, 32'(acc_out), 0);
    check({tag, "_zero_cnt"}, 32'(zero_cnt), 0);
    check({tag, "_max"}, 32'(max_out), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sm_r      = '0;
    sm_zero_r = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_cleared("in_reset");
    rst_n = 1'b1;
    step();

    // Idle: nothing accepted, nothing produced.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_in_ready", 32'(in_ready), 1);
    end
    check_cleared("idle");

    // Back-to-back window with downstream always ready.
    out_ready = 1'b1;
    send(5, 1'b0);
    send(0, 1'b1);
    send(1023, 1'b0);
    check("pre_last_out_valid", 32'(out_valid), 0);
    send(7, 1'b0);
    check_result("win1", 1035, 1, 1023, 0);
    step();
    check_cleared("win1_consumed");

    // Stalled result with in_valid activity during HOLD.
    out_ready = 1'b0;
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b0);
    in_valid = 1'b1;
    sm_r     = 10'd9;
    for (int i = 0; i < 5; i++) begin
      check_result("stall", 8, 0, 2, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    check_cleared("stall_consumed");
    in_valid = 1'b0;
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    check_result("after_stall", 4, 0, 1, 0);
    step();

    // Reset mid-window discards the partial sums.
    send(3, 1'b1);
    send(4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    step();
    rst_n = 1'b1;
    step();
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    check_result("post_reset", 4, 0, 1, 0);
    step();

    // Overflow on the narrow instance; the wide one holds the full sum.
    send(1023, 1'b0);
    send(1023, 1'b0);
    send(1023, 1'b0);
    send(1023, 1'b0);
    check_result("wide_ovf", 4092, 0, 1023, 0);
    check("small_out_valid", 32'(out_valid_s), 1);
    check("small_ovf", 32'(ovf_s), 1);
`ifdef SUM_WINDOW_ACC_SAT_EN
    check("small_acc_sat", 32'(acc_out_s), 1023);
`else
    check("small_acc_wrap", 32'(acc_out_s), 1020);
`endif
    check("small_max", 32'(max_out_s), 1023);
    step();
    check("small_ovf_cleared", 32'(ovf_s), 0);
    check("small_acc_cleared", 32'(acc_out_s), 0);

    // All-zero window counts every flag.
    send(0, 1'b1);
    send(0, 1'b1);
    send(0, 1'b1);
    send(0, 1'b1);
    check_result("zeros", 0, 4, 0, 0);
    step();
    check_cleared("zeros_consumed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
